// File: rtl/op_select.sv
// op_select: button synchronizer/debouncer, operation-select latch and counter-mode display counter.
module op_select #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 12500000
) (
    input  logic        clk_pi,
    input  logic        rst_n_pi,
    input  logic [3:0]  btn_pi,
    output logic [3:0]  op_po,
    output logic [3:0]  press_po,
    output logic [15:0] counter_po
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DW-1:0] DC_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

    logic [3:0]    sync1, s, db, db_q, op_next;
    logic [DW-1:0] dc [4];
    logic [PW-1:0] pre;
    logic [2:0]    pop;

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            sync1 <= '0;
            s     <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int k = 0; k < 4; k++) dc[k] <= '0;
        end else begin
            sync1 <= btn_pi;
            s     <= sync1;
            db_q  <= db;
            for (int k = 0; k < 4; k++) begin
                if (s[k] == db[k]) begin
                    dc[k] <= '0;
                end else if (dc[k] == DC_MAX) begin
                    db[k] <= s[k];
                    dc[k] <= '0;
                end else begin
                    dc[k] <= dc[k] + 1'b1;
                end
            end
        end
    end

    assign press_po = db & ~db_q;

    // Any press with two or more buttons held is a chord; otherwise exactly one bit is pressed.
    always_comb begin
        pop     = 3'(db[0]) + 3'(db[1]) + 3'(db[2]) + 3'(db[3]);
        op_next = press_po == 4'b0000 ? op_po :
                  pop >= 3'd2         ? 4'b1111 :
                  op_po == press_po   ? 4'b0000 : press_po;
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            op_po      <= '0;
            pre        <= '0;
            counter_po <= '0;
        end else begin
            op_po <= op_next;
            if (op_po != 4'b1111) begin
                pre <= '0;
            end else if (pre == PRE_MAX) begin
                pre        <= '0;
                counter_po <= counter_po + 16'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end
endmodule

// File: doc/op_select.md
# op_select

Front-end input stage for the four-button arithmetic calculator. It synchronizes and debounces the raw push buttons and latches the operation select. It also generates the free-running display count consumed by the calculator's counter mode. Outputs `op_po` and `counter_po` drive the calculator's `op_pi` and `counter_pi` directly.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive clocks a synchronized button level must differ from its debounced level before the debounced level flips. Must be ≥ 2.
- `TICK_CYCLES`, default 12500000: clocks per `counter_po` increment in counter mode. Must be ≥ 1.
- `clk_pi`, in, 1: single clock. All state updates on the rising edge.
- `rst_n_pi`, in, 1: asynchronous, active-low reset.
- `btn_pi`, in, 4: raw active-high buttons. Asynchronous and bouncy. Bit i selects operation one-hot `1<<i`.
- `op_po`, out, 4: latched operation select. Takes exactly one of three forms: 0000 (concat), a one-hot value, or 1111 (counter mode).
- `press_po`, out, 4: per-button press pulse, one clock wide.
- `counter_po`, out, 16: display counter.

## Operation
- **Reset** (`rst_n_pi` low) immediately clears all state:
  - synchronizers, debounced levels, and debounce counters go to 0;
  - prescaler goes to 0;
  - outputs reset to `op_po`=0000, `press_po`=0000, `counter_po`=0x0000.
- **Synchronizer:** two flops per bit. The value at the second stage is `s[i]`.
- **Debounce**, per bit, with debounced level `db[i]` and counter `dc[i]`:
  - If `s[i]==db[i]`, then `dc[i]`←0.
  - Else if `dc[i]==DEBOUNCE_CYCLES-1`, then `db[i]`←`s[i]` and `dc[i]`←0.
  - Else `dc[i]`←`dc[i]+1`.
  - Any bounce shorter than `DEBOUNCE_CYCLES` clocks is discarded.
- **Press pulse:** `press_po[i] = db[i] & ~db_q[i]`, where `db_q` is `db` delayed one clock. Releases produce no pulse.
- **Op latch:** a state machine whose state is `op_po`. It updates only on edges where `press_po`≠0, evaluated in priority order:
  1. If popcount(`db`) ≥ 2, then `op_po`←1111 (chord). This also covers simultaneous presses.
  2. Else, for the single pressed bit i: if `op_po==1<<i`, then `op_po`←0000 (toggle off); otherwise `op_po`←`1<<i`. This rule also exits 1111.
- **Counter:** active only while `op_po`==1111.
  - Prescaler counts 0..`TICK_CYCLES-1`. On its terminal count it returns to 0 and `counter_po` increments, wrapping 0xFFFF→0x0000.
  - Outside counter mode, the prescaler is held at 0 and `counter_po` holds its value.
  - Entering counter mode does not clear `counter_po`.

## Timing
- Let D=`DEBOUNCE_CYCLES`. Raw `btn_pi[i]` rises before edge e0 and then stays stable:
  - `s[i]`=1 after e1;
  - `db[i]`=1 after e(1+D);
  - `press_po[i]` is high between e(1+D) and e(2+D);
  - `op_po` updates at e(2+D).
- Release follows the same latency but produces no `press_po` and no `op_po` change.
- Counter mode entered at edge E: first increment at edge E+`TICK_CYCLES`, then every `TICK_CYCLES` clocks after that.
- Reset asserted mid-debounce or mid-tick: that progress is lost.
  - A button held through reset release is treated as a new press: it pulses D+1 edges after release.
- `press_po` is never high for two consecutive clocks on the same bit.

## Test plan
Bench parameters: D=4, `TICK_CYCLES`=3.
- **Reset values:** reset low, `btn_pi`=1111 → all outputs 0. Then release reset, hold `btn_pi[1]` only → `press_po`=0010 for one clock at edge 5; `op_po`=0010 after edge 6.
- **Bounce rejection:** `btn_pi[2]` high 3 clocks, low 1, high 3, low → no `press_po`; `op_po` unchanged.
- **Toggle:** press/release `btn_pi[0]` twice with `op_po`=0000 → `op_po` 0001, then 0000.
- **Select change:** `op_po`=0100, press `btn_pi[3]` → `op_po`=1000.
- **Chord to counter mode:** hold `btn_pi[0]`, then press `btn_pi[2]` → `op_po`=1111.
  - `counter_po` increments every 3 clocks.
  - Force `counter_po`=0xFFFE; after 6 clocks → 0x0000.
  - Single press of `btn_pi[1]` → `op_po`=0010 and `counter_po` frozen.
- **Async reset mid-count:** assert `rst_n_pi` between clock edges while counting → `counter_po`=0 and `op_po`=0 immediately, without waiting for a clock edge.
